mul_unit: RTL
=============

// Module: mul_unit
// PURPOSE
//  Iterative multiplier in the EX stage for RV32M MUL/MULH/MULHSU/MULHU.
//  Consumes the ID/EX multiply type and forwarded operands. Produces mul_finish, which the
//  hazard detection unit uses to stall PC and IF/ID while (ID_EX_MULtype != 0 && !mul_finish).
//  Result goes to the EX-stage ALU output mux.
// PARAMETERS
//  XLEN      32  operand/result width
//  BITS_PC   1   multiplier bits retired per cycle (1,2,4); N = XLEN/BITS_PC iterations
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     synchronous reset, active low
//  flush        in   1     kill in-flight op (EX squash)
//  MULtype      in   2     from ID/EX: 0=none 1=MUL 2=MULH 3=MULHSU/MULHU
//  mul_hu       in   1     with MULtype==3: 1=MULHU, 0=MULHSU
//  rs1_data     in   XLEN  forwarded operand A (multiplicand)
//  rs2_data     in   XLEN  forwarded operand B (multiplier)
//  mul_busy     out  1     op in progress (state BUSY or DONE)
//  mul_finish   out  1     1-cycle pulse; mul_result valid
//  mul_result   out  XLEN  selected 32 bits of the 64-bit product
// BEHAVIOUR
//  Reset: on the rst_n==0 edge, state=IDLE, counter=0, accumulators=0.
//   mul_busy=0, mul_finish=0, mul_result=0. Reset overrides flush and any op in progress.
//  FSM: IDLE -> BUSY -> DONE -> IDLE. All outputs decode from registered state/regs.
//  IDLE: when MULtype!=0 and flush=0, latch rs1/rs2, type, and mul_hu.
//   Latch operand magnitudes plus neg flag. Then count=0 and go to BUSY.
//   Operands must be latched: forwarded values can change while the pipe is stalled.
//  Signedness: A is signed for MULH and MULHSU. B is signed for MULH only. MUL is sign-agnostic.
//   Form unsigned magnitudes. neg = (A_signed & A[31]) ^ (B_signed & B[31]).
//  BUSY: each cycle add BITS_PC partial products (shift-add) into the 64-bit accumulator.
//   Shift the multiplier by BITS_PC. count++. After N cycles go to DONE.
//   BUSY ignores MULtype and operand changes.
//  DONE: product = neg ? -acc (64-bit two's complement) : acc.
//   Select the result: MUL=product[31:0]; MULH, MULHSU and MULHU=product[63:32].
//   mul_result is registered on entry to DONE and holds until the next start or reset.
//   mul_finish=1 for exactly one cycle. Next state is always IDLE, even though MULtype is
//   still nonzero this cycle (the same instruction is retiring, so there is no restart).
//  Latency: op enters ID/EX in cycle T and is latched at the end of T.
//   BUSY spans T+1..T+N. DONE and mul_finish occur in T+N+1. EX occupancy is N+2 cycles.
//  Back-to-back ops: the next mul arrives in the cycle after DONE, sees IDLE, and starts.
//   mul_finish is 0 in that cycle, so the stall holds correctly.
//  flush=1 (any state): next state IDLE, with no mul_finish pulse for the killed op.
//   Outputs in the flush cycle still reflect the current state. mul_result is unchanged.
//  Zero operand: still N iterations, with no early exit. The result is 0.
//  Overflow: MUL discards the high half. There are no exceptions.
// TESTING
//  Reset mid-op: start MUL and drop rst_n at BUSY cycle 5.
//   -> Next cycle busy=0, finish=0, result=0. No pulse afterwards.
//  MUL 0xFFFFFFFF*0xFFFFFFFF, BITS_PC=1, op in cycle T.
//   -> finish only at T+33, result=0x00000001.
//  Signed variants:
//   MULH   0x80000000*0x80000000 -> 0x40000000.
//   MULHU  0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//   MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  Operand change: MUL 7*6, then rs1=0x1234 from BUSY cycle 2 on.
//   -> result=0x0000002A.
//  Back-to-back: MUL 3*5 then MULHU 0x10000*0x10000.
//   -> Two 1-cycle finish pulses 34 cycles apart, results 0x0F then 0x00000001.
//  Flush: flush at BUSY cycle 10 -> IDLE, no finish pulse.
//   Then MUL 0*0x7FFFFFFF with BITS_PC=4 -> finish at T+9, result=0.

Source files
------------

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU in the EX stage.
// Retires BITS_PC multiplier bits per cycle and pulses mul_finish for one cycle.
module mul_unit #(
   parameter int XLEN    = 32,
   parameter int BITS_PC = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic [1:0]      MULtype,
   input  logic            mul_hu,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            mul_busy,
   output logic            mul_finish,
   output logic [XLEN-1:0] mul_result
);

   localparam int N  = XLEN / BITS_PC;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [2*XLEN-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0]     mplier_q, mplier_d;
   logic                neg_q, neg_d;
   logic                is_mul_q, is_mul_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                a_signed;
   logic                b_signed;
   logic                a_neg;
   logic                b_neg;
   logic [XLEN-1:0]     a_mag;
   logic [XLEN-1:0]     b_mag;
   logic [2*XLEN-1:0]   acc_n;
   logic [2*XLEN-1:0]   prod;

   always_comb begin
      a_signed = (MULtype == 2'd2) || ((MULtype == 2'd3) && !mul_hu);
      b_signed = (MULtype == 2'd2);
      a_neg    = a_signed & rs1_data[XLEN-1];
      b_neg    = b_signed & rs2_data[XLEN-1];
      a_mag    = a_neg ? (~rs1_data + 1'b1) : rs1_data;
      b_mag    = b_neg ? (~rs2_data + 1'b1) : rs2_data;
   end

   // One iteration: add the partial products selected by the low multiplier bits.
   always_comb begin
      acc_n = acc_q;
      for (int i = 0; i < BITS_PC; i++) begin
         if (mplier_q[i]) begin
            acc_n = acc_n + (mcand_q << i);
         end
      end
      prod = neg_q ? (~acc_n + 1'b1) : acc_n;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;
      is_mul_d = is_mul_q;
      result_d = result_q;

      unique case (state_q)
         S_IDLE: begin
            if (MULtype != 2'd0) begin
               mcand_d  = {{XLEN{1'b0}}, a_mag};
               mplier_d = b_mag;
               neg_d    = a_neg ^ b_neg;
               is_mul_d = (MULtype == 2'd1);
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            acc_d    = acc_n;
            mcand_d  = mcand_q << BITS_PC;
            mplier_d = mplier_q >> BITS_PC;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d  = S_DONE;
               result_d = is_mul_q ? prod[XLEN-1:0]
                                   : prod[2*XLEN-1:XLEN];
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A squashed op never publishes a result.
      if (flush) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
         is_mul_q <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         neg_q    <= neg_d;
         is_mul_q <= is_mul_d;
         result_q <= result_d;
      end
   end

   assign mul_busy   = (state_q != S_IDLE);
   assign mul_finish = (state_q == S_DONE);
   assign mul_result = result_q;

endmodule
